// File: rtl/instr_fetch_if.sv
// Fetch bundle: consumer handshake toward control plus the synchronous instruction-array port.
// master = fetch unit side, slave = control/array side.
interface instr_fetch_if;
   logic        rom_rd;
   logic [15:0] ROM_data;
   logic        rom_valid;
   logic [11:0] pc_out;
   logic        redirect;
   logic [11:0] redirect_pc;
   logic        imem_en;
   logic [11:0] imem_addr;
   logic [15:0] imem_rdata;

   modport master (
      input  rom_rd, redirect, redirect_pc, imem_rdata,
      output ROM_data, rom_valid, pc_out, imem_en, imem_addr
   );

   modport slave (
      output rom_rd, redirect, redirect_pc, imem_rdata,
      input  ROM_data, rom_valid, pc_out, imem_en, imem_addr
   );
endinterface

// File: rtl/instr_fetch.sv
// Instruction prefetcher: 2-entry {instr, pc} buffer fed from a 1-cycle-latency array.
// Optional IFETCH_PERF_EN adds fetch_cnt/flush_cnt performance counters.
//
// state | meaning
// BOOT  | first cycle after reset, no fetch issued
// RUN   | normal prefetch, responses pushed into buffer
// REDIR | cycle after a redirect; the response arriving now is stale and dropped
module instr_fetch (
   input  logic          clk,
   input  logic          rst,
`ifdef IFETCH_PERF_EN
   output logic [15:0]   fetch_cnt,
   output logic [15:0]   flush_cnt,
`endif
   instr_fetch_if.master bus
);
   typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, REDIR = 2'd2} state_t;

   state_t      state;
   logic [1:0]  count;
   logic        inflight;
   logic [11:0] fetch_pc;
   logic [11:0] issue_pc;
   logic [15:0] instr_q [2];
   logic [11:0] pc_q [2];
   logic        head_valid;
   logic        pop;
   logic        push;
   logic        fetch_go;
   logic [2:0]  occupancy;

   // Occupancy counts in-flight reads, so a read is only issued when its slot is guaranteed.
   always_comb begin
      head_valid = ~rst & (count != 2'd0);
      pop        = bus.rom_rd & head_valid & ~bus.redirect;
      push       = inflight & (state != REDIR);
      occupancy  = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
      fetch_go   = ~rst & (state != BOOT) & (occupancy < 3'd2);
   end

   assign bus.rom_valid = head_valid;
   assign bus.ROM_data  = head_valid ? instr_q[0] : 16'h0000;
   assign bus.pc_out    = head_valid ? pc_q[0] : 12'h000;
   assign bus.imem_en   = fetch_go;
   assign bus.imem_addr = fetch_pc;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= BOOT;
         count    <= 2'd0;
         inflight <= 1'b0;
         fetch_pc <= 12'h000;
         issue_pc <= 12'h000;
      end else begin
         inflight <= fetch_go;
         if (fetch_go)
            issue_pc <= fetch_pc;
         if (bus.redirect) begin
            state    <= REDIR;
            count    <= 2'd0;
            fetch_pc <= bus.redirect_pc;
         end else begin
            state <= RUN;
            if (fetch_go)
               fetch_pc <= fetch_pc + 12'd1;
            case ({push, pop})
               2'b10: begin
                  instr_q[count[0]] <= bus.imem_rdata;
                  pc_q[count[0]]    <= issue_pc;
                  count             <= count + 2'd1;
               end
               2'b01: begin
                  instr_q[0] <= instr_q[1];
                  pc_q[0]    <= pc_q[1];
                  count      <= count - 2'd1;
               end
               2'b11: begin
                  if (count == 2'd1) begin
                     instr_q[0] <= bus.imem_rdata;
                     pc_q[0]    <= issue_pc;
                  end else begin
                     instr_q[0] <= instr_q[1];
                     pc_q[0]    <= pc_q[1];
                     instr_q[1] <= bus.imem_rdata;
                     pc_q[1]    <= issue_pc;
                  end
               end
               default: ;
            endcase
         end
      end
   end

`ifdef IFETCH_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_cnt <= 16'h0000;
         flush_cnt <= 16'h0000;
      end else begin
         if (pop)
            fetch_cnt <= fetch_cnt + 16'd1;
         if (bus.redirect)
            flush_cnt <= flush_cnt + 16'd1;
      end
   end
`endif
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port rom_rd  input  1  control consumes the instruction on ROM_data this cycle.
REQ-004 SHALL have port ROM_data  output  16  instruction at buffer head; 16'h0000 (NOP) when buffer is empty.
REQ-005 SHALL have port rom_valid  output  1  ROM_data holds a real instruction.
REQ-006 SHALL have port pc_out  output  12  word address of ROM_data; 12'h000 when empty.
REQ-007 SHALL have port redirect  input  1  jump or taken branch; refetch from redirect_pc.
REQ-008 SHALL have port redirect_pc  input  12  redirect target word address.
REQ-009 SHALL have port imem_en  output  1  read strobe to the synchronous instruction array.
REQ-010 SHALL have port imem_addr  output  12  array word address.
REQ-011 SHALL have port imem_rdata  input  16  array data, valid exactly 1 cycle after imem_en.

Function
REQ-012 SHALL hold a 2-entry FIFO of {instruction, pc}; ROM_data and pc_out SHALL show the head combinationally; rom_valid = (count != 0).
REQ-013 SHALL implement FSM BOOT -> RUN after one cycle; RUN -> REDIR on redirect; REDIR -> RUN after one cycle, or stay in REDIR if redirect is asserted again.
REQ-014 BOOT SHALL keep imem_en = 0.
REQ-015 In RUN/REDIR, imem_en SHALL be 1 iff count + inflight - pop < 2, where inflight is the prior-cycle imem_en and pop = rom_rd & rom_valid & ~redirect.
REQ-016 imem_addr SHALL equal the fetch PC; each issued read SHALL increment the fetch PC by 1, wrapping 12'hFFF -> 12'h000.
REQ-017 A response SHALL be pushed with its issue address, except while in REDIR when the response belongs to a pre-redirect read, which SHALL be discarded.
REQ-018 rom_rd with rom_valid = 0 SHALL be ignored; push and pop in the same cycle SHALL leave count unchanged.
REQ-019 redirect in cycle R SHALL clear the FIFO at end of R and load the fetch PC with redirect_pc; imem_en SHALL be 1 with imem_addr = redirect_pc in R+1, and rom_valid SHALL rise in R+3.
REQ-020 redirect and rom_rd in the same cycle: redirect SHALL win and no pop SHALL be counted.
REQ-021 After reset release (cycle 0 = BOOT), imem_en SHALL assert in cycle 1 with addr 0, and rom_valid SHALL rise in cycle 3 with pc_out = 0.
REQ-022 FIFO SHALL never overflow; a push into a full FIFO SHALL be impossible by construction of REQ-015.

Reset
REQ-023 While rst = 1 the block SHALL set state = BOOT, count = 0, inflight = 0, fetch PC = 0, imem_en = 0, rom_valid = 0, ROM_data = 16'h0000 and pc_out = 0.
REQ-024 rst asserted mid-operation SHALL drop all buffered and in-flight data; the first post-reset fetch SHALL be address 0.

Configuration
REQ-025 With IFETCH_PERF_EN defined, the block SHALL add outputs fetch_cnt[15:0] (+1 per pop) and flush_cnt[15:0] (+1 per redirect cycle); both SHALL wrap at 16'hFFFF -> 0 and be cleared by rst.
REQ-026 Without IFETCH_PERF_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-027 Reset release, rom_rd = 0 -> imem_en in cycle 1 and cycle 2 only (addrs 0, 1); count = 2; ROM_data = mem[0]; no further imem_en.
REQ-028 rom_rd held at 1 with memory mem[i] = i -> one instruction per cycle from cycle 3, pc_out 0, 1, 2, ... with no gaps.
REQ-029 redirect = 1, redirect_pc = 12'h0A0 in cycle R with a full FIFO -> rom_valid = 0 in R+1 and R+2, ROM_data = 0; rom_valid = 1 in R+3 with pc_out = 12'h0A0; no stale word is ever delivered.
REQ-030 Fetch PC at 12'hFFE with continuous rom_rd -> pc_out sequence FFE, FFF, 000, 001.
REQ-031 redirect in R and again in R+1 (targets 12'h010, 12'h020) -> first delivered pc_out = 12'h020 in R+4; 12'h010 is never delivered.
REQ-032 rst pulse while FIFO is full and a read is in flight -> all outputs return to reset values next cycle; with IFETCH_PERF_EN defined, after 5 pops and 2 redirects fetch_cnt = 5 and flush_cnt = 2.
